// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
// Holds the controller state encoding and the default bank geometry.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWAP
    } state_t;

    localparam int NUM_TAPS = 31;
    localparam int COEFF_W  = 16;

    // Bits needed to index n entries, never less than one.
    function automatic int min_addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Software configuration port of the FIR coefficient controller.
// The master drives writes and commits, the slave reports status.
interface fir_cfg_if
    import fir_ctrl_pkg::*;
#(
    parameter int coeff_width = COEFF_W,
    parameter int addr_width  = 5
);

    logic                   cfg_wr_i;
    logic [addr_width-1:0]  cfg_addr_i;
    logic [coeff_width-1:0] cfg_data_i;
    logic                   cfg_commit_i;
    logic                   cfg_busy_o;
    logic                   cfg_err_o;
    logic                   swap_done_o;
    logic                   dirty_o;

    modport master (
        output cfg_wr_i,
        output cfg_addr_i,
        output cfg_data_i,
        output cfg_commit_i,
        input  cfg_busy_o,
        input  cfg_err_o,
        input  swap_done_o,
        input  dirty_o
    );

    modport slave (
        input  cfg_wr_i,
        input  cfg_addr_i,
        input  cfg_data_i,
        input  cfg_commit_i,
        output cfg_busy_o,
        output cfg_err_o,
        output swap_done_o,
        output dirty_o
    );

endinterface

// File: rtl/fir_coeff_ctrl_bank.sv
// Shadow and active coefficient register banks.
// Shadow takes single-word writes; active copies shadow on swap.
module fir_coeff_bank
    import fir_ctrl_pkg::*;
#(
    parameter int coeff_width = COEFF_W,
    parameter int num_taps    = NUM_TAPS,
    parameter int addr_width  = 5
) (
    input  logic                            aclk,
    input  logic                            rst_i,
    input  logic                            wr_en,
    input  logic [addr_width-1:0]           wr_addr,
    input  logic [coeff_width-1:0]          wr_data,
    input  logic                            swap,
    output logic [num_taps*coeff_width-1:0] coeff_o
);

    logic [coeff_width-1:0] shadow [num_taps];
    logic [coeff_width-1:0] active [num_taps];

    always_ff @(posedge aclk) begin
        if (rst_i) begin
            for (int k = 0; k < num_taps; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
            if (swap) begin
                active <= shadow;
            end
        end
    end

    for (genvar k = 0; k < num_taps; k++) begin : g_flat
        assign coeff_o[k*coeff_width +: coeff_width] = active[k];
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Run-time coefficient controller for the FIR filter: swaps the
// shadow bank into the active bank only at a frame edge or idle gap.
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int coeff_width  = COEFF_W,
    parameter int num_taps     = NUM_TAPS,
    parameter int addr_width   = 5,
    parameter int idle_timeout = 64
) (
    input  logic                            aclk,
    input  logic                            rst_i,
    fir_cfg_if.slave                        cfg,
    input  logic                            mon_tvalid_i,
    input  logic                            mon_tready_i,
    input  logic                            mon_tlast_i,
    output logic [num_taps*coeff_width-1:0] coeff_o
);

    localparam int CNT_W = min_addr_w(idle_timeout + 1);
    localparam logic [CNT_W-1:0] TO = CNT_W'(idle_timeout);
    localparam logic [addr_width:0] NT = (addr_width + 1)'(num_taps);

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             boundary;
    logic             timeout_hit;
    logic             wr_ok;
    logic             err_n;
    logic             busy_q;
    logic             err_q;
    logic             done_q;
    logic             dirty_q;

    assign boundary = mon_tvalid_i & mon_tready_i & mon_tlast_i;
    assign cnt_inc  = (cnt_q == TO) ? cnt_q : cnt_q + 1'b1;

    // Fire on the edge where the count reaches the limit, not one later.
    assign timeout_hit = (idle_timeout != 0) && !mon_tvalid_i
                         && (cnt_inc == TO);

    assign wr_ok = cfg.cfg_wr_i && (state_q == IDLE)
                   && ({1'b0, cfg.cfg_addr_i} < NT);

    assign err_n = (cfg.cfg_wr_i && !wr_ok)
                   || (cfg.cfg_commit_i && (state_q != IDLE));

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg.cfg_commit_i) state_n = PENDING;
            end
            PENDING: begin
                if (boundary || timeout_hit) state_n = SWAP;
            end
            SWAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_n;
            busy_q  <= (state_n != IDLE);
            err_q   <= err_n;
            done_q  <= (state_q == SWAP);
            if (state_q != PENDING || mon_tvalid_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_inc;
            end
            if (state_q == SWAP) begin
                dirty_q <= 1'b0;
            end else if (wr_ok) begin
                dirty_q <= 1'b1;
            end
        end
    end

    assign cfg.cfg_busy_o  = busy_q;
    assign cfg.cfg_err_o   = err_q;
    assign cfg.swap_done_o = done_q;
    assign cfg.dirty_o     = dirty_q;

    fir_coeff_bank #(
        .coeff_width (coeff_width),
        .num_taps    (num_taps),
        .addr_width  (addr_width)
    ) u_bank (
        .aclk    (aclk),
        .rst_i   (rst_i),
        .wr_en   (wr_ok),
        .wr_addr (cfg.cfg_addr_i),
        .wr_data (cfg.cfg_data_i),
        .swap    (state_q == SWAP),
        .coeff_o (coeff_o)
    );

endmodule
